// File: rtl/bus_sequencer.sv
// Control-step sequencer: drives bus mux select and load strobes for fetch (T0-T2) and execute (T3-T6).
// Latency start->done 7 cycles (ALU) or 8 (MUL/DIV) plus one per memory wait; stalls in T1 on mem_ready, faults after MEM_WAIT_MAX.
module bus_sequencer #(
    parameter logic [4:0] ALU_LAST     = 5'd14,
    parameter logic [4:0] OPC_MUL      = 5'd15,
    parameter logic [4:0] OPC_DIV      = 5'd16,
    parameter int         MEM_WAIT_MAX = 15
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic [4:0]  bus_sel,
    output logic        mar_in,
    output logic        pc_in,
    output logic        inc_pc,
    output logic        mem_read,
    output logic        mdr_in,
    output logic        ir_in,
    output logic        y_in,
    output logic        z_in,
    output logic        hi_in,
    output logic        lo_in,
    output logic [15:0] reg_in,
    output logic [4:0]  alu_op,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, FAULT
    } state_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  rc;
        logic [14:0] rsvd;
    } ir_t;

    localparam logic [4:0] SEL_ZHI = 5'd19;
    localparam logic [4:0] SEL_ZLO = 5'd20;
    localparam logic [4:0] SEL_PC  = 5'd21;
    localparam logic [4:0] SEL_MDR = 5'd22;

    localparam int             CW        = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [CW-1:0]  WAIT_LAST = CW'(MEM_WAIT_MAX - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          done_q;
    ir_t           ir_f;
    logic          is_alu, is_muldiv;
    logic          unused_ir;

    assign ir_f      = ir;
    assign unused_ir = ^ir_f.rsvd;
    assign is_alu    = (ir_f.op <= ALU_LAST);
    assign is_muldiv = (ir_f.op == OPC_MUL) || (ir_f.op == OPC_DIV);

    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= IDLE;
            wait_cnt <= '0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            // done must fire only in the IDLE cycle right after the final step
            done_q <= ((state == T5) && is_alu) || (state == T6);
            if (state == T0)
                wait_cnt <= '0;
            else if ((state == T1) && !mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        bus_sel   = '0;
        mar_in    = 1'b0;
        pc_in     = 1'b0;
        inc_pc    = 1'b0;
        mem_read  = 1'b0;
        mdr_in    = 1'b0;
        ir_in     = 1'b0;
        y_in      = 1'b0;
        z_in      = 1'b0;
        hi_in     = 1'b0;
        lo_in     = 1'b0;
        reg_in    = '0;
        alu_op    = '0;
        case (state)
            IDLE: begin
                if (start) state_nxt = T0;
            end
            T0: begin
                bus_sel   = SEL_PC;
                mar_in    = 1'b1;
                inc_pc    = 1'b1;
                z_in      = 1'b1;
                state_nxt = T1;
            end
            T1: begin
                bus_sel  = SEL_ZLO;
                mem_read = 1'b1;
                if (mem_ready) begin
                    pc_in     = 1'b1;
                    mdr_in    = 1'b1;
                    state_nxt = T2;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = FAULT;
                end
            end
            T2: begin
                bus_sel   = SEL_MDR;
                ir_in     = 1'b1;
                state_nxt = T3;
            end
            T3: begin
                bus_sel   = {1'b0, ir_f.rb} + 5'd1;
                y_in      = 1'b1;
                state_nxt = (is_alu || is_muldiv) ? T4 : FAULT;
            end
            T4: begin
                bus_sel   = {1'b0, ir_f.rc} + 5'd1;
                z_in      = 1'b1;
                alu_op    = ir_f.op;
                state_nxt = T5;
            end
            T5: begin
                bus_sel = SEL_ZLO;
                if (is_alu) begin
                    reg_in    = 16'(1) << ir_f.ra;
                    state_nxt = IDLE;
                end else begin
                    lo_in     = 1'b1;
                    state_nxt = T6;
                end
            end
            T6: begin
                bus_sel   = SEL_ZHI;
                hi_in     = 1'b1;
                state_nxt = IDLE;
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy  = (state != IDLE) && (state != FAULT);
    assign done  = (state == IDLE) && done_q;
    assign error = (state == FAULT);

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer: walks every control step cycle by cycle against hand-computed vectors.
module tb_bus_sequencer;

    logic        clock = 1'b0;
    logic        clear, start, mem_ready;
    logic [31:0] ir;
    logic [4:0]  bus_sel, alu_op;
    logic        mar_in, pc_in, inc_pc, mem_read, mdr_in, ir_in, y_in, z_in, hi_in, lo_in;
    logic [15:0] reg_in;
    logic        busy, done, error;

    int total = 0;
    int bad   = 0;

    // strobe bit positions: {mar_in,pc_in,inc_pc,mem_read,mdr_in,ir_in,y_in,z_in,hi_in,lo_in}
    localparam logic [9:0] MAR = 10'h200, PCI = 10'h100, INC = 10'h080, MRD = 10'h040, MDR = 10'h020;
    localparam logic [9:0] IRI = 10'h010, YIN = 10'h008, ZIN = 10'h004, HIN = 10'h002, LOI = 10'h001;

    bus_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .ir(ir), .mem_ready(mem_ready),
        .bus_sel(bus_sel), .mar_in(mar_in), .pc_in(pc_in), .inc_pc(inc_pc), .mem_read(mem_read),
        .mdr_in(mdr_in), .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in),
        .reg_in(reg_in), .alu_op(alu_op), .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] mk_ir(int op, int ra, int rb, int rc);
        return {op[4:0], ra[3:0], rb[3:0], rc[3:0], 15'd0};
    endfunction

    task automatic chk(string tag, logic [4:0] b, logic [9:0] s, logic [15:0] r,
                       logic [4:0] a, logic bz, logic dn, logic er);
        logic [38:0] obs, exp;
        #1;
        obs = {bus_sel, mar_in, pc_in, inc_pc, mem_read, mdr_in, ir_in, y_in, z_in, hi_in, lo_in,
               reg_in, alu_op, busy, done, error};
        exp = {b, s, r, a, bz, dn, er};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // From T0 (start already sampled) through T2 with zero-wait memory; ends in T3.
    task automatic fetch(string tag);
        mem_ready = 1'b1;
        chk({tag, "_t0"}, 5'd21, MAR | INC | ZIN, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        chk({tag, "_t1"}, 5'd20, MRD | PCI | MDR, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        chk({tag, "_t2"}, 5'd22, IRI, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        clear = 1'b1; start = 1'b0; mem_ready = 1'b1; ir = '0;
        step();
        step();
        chk("reset", 5'd0, 10'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        clear = 1'b0;

        // ADD r3,r1,r2 with zero-wait memory: done in cycle 7
        ir = mk_ir(0, 3, 1, 2); start = 1'b1;
        chk("add_idle", 5'd0, 10'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(); start = 1'b0;
        fetch("add");
        chk("add_t3", 5'd2, YIN, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0); step();
        chk("add_t4", 5'd3, ZIN, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0); step();
        chk("add_t5", 5'd20, 10'h0, 16'h0008, 5'd0, 1'b1, 1'b0, 1'b0); step();
        chk("add_done", 5'd0, 10'h0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0); step();
        chk("add_after", 5'd0, 10'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Same ADD, three wait cycles in T1, start pulses while busy: done in cycle 10
        start = 1'b1;
        step(); start = 1'b0;
        chk("wait_t0", 5'd21, MAR | INC | ZIN, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0); step();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start = (i == 1);
            chk("wait_t1_stall", 5'd20, MRD, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
            step();
        end
        start = 1'b0; mem_ready = 1'b1;
        chk("wait_t1_rdy", 5'd20, MRD | PCI | MDR, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0); step();
        start = 1'b1;
        chk("wait_t2", 5'd22, IRI, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0); step();
        start = 1'b0;
        chk("wait_t3", 5'd2, YIN, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0); step();
        chk("wait_t4", 5'd3, ZIN, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0); step();
        chk("wait_t5", 5'd20, 10'h0, 16'h0008, 5'd0, 1'b1, 1'b0, 1'b0); step();
        // back-to-back: MUL started in the done cycle
        ir = mk_ir(15, 7, 4, 5); start = 1'b1;
        chk("wait_done", 5'd0, 10'h0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0); step();
        start = 1'b0;

        // MUL r7,r4,r5
        fetch("mul");
        chk("mul_t3", 5'd5, YIN, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0); step();
        chk("mul_t4", 5'd6, ZIN, 16'h0, 5'd15, 1'b1, 1'b0, 1'b0); step();
        chk("mul_t5", 5'd20, LOI, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0); step();
        chk("mul_t6", 5'd19, HIN, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0); step();
        chk("mul_done", 5'd0, 10'h0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0); step();

        // DIV r2,r9,r0
        ir = mk_ir(16, 2, 9, 0); start = 1'b1;
        step(); start = 1'b0;
        fetch("div");
        chk("div_t3", 5'd10, YIN, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0); step();
        chk("div_t4", 5'd1, ZIN, 16'h0, 5'd16, 1'b1, 1'b0, 1'b0); step();
        chk("div_t5", 5'd20, LOI, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0); step();
        chk("div_t6", 5'd19, HIN, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0); step();
        chk("div_done", 5'd0, 10'h0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0); step();

        // Last ALU opcode, highest registers: ra=15, rb=0, rc=15
        ir = mk_ir(14, 15, 0, 15); start = 1'b1;
        step(); start = 1'b0;
        fetch("alu14");
        chk("alu14_t3", 5'd1, YIN, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0); step();
        chk("alu14_t4", 5'd16, ZIN, 16'h0, 5'd14, 1'b1, 1'b0, 1'b0); step();
        chk("alu14_t5", 5'd20, 10'h0, 16'h8000, 5'd0, 1'b1, 1'b0, 1'b0); step();
        chk("alu14_done", 5'd0, 10'h0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0); step();

        // Illegal op 31: FAULT after T3, start ignored, clear recovers
        ir = mk_ir(31, 1, 6, 2); start = 1'b1;
        step(); start = 1'b0;
        fetch("ill31");
        chk("ill31_t3", 5'd7, YIN, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0); step();
        start = 1'b1;
        chk("ill31_fault", 5'd0, 10'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1); step();
        chk("ill31_start_ign", 5'd0, 10'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1); step();
        clear = 1'b1;
        step(); clear = 1'b0; start = 1'b0;
        chk("ill31_clear", 5'd0, 10'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Illegal op 17, just past DIV
        ir = mk_ir(17, 1, 3, 2); start = 1'b1;
        step(); start = 1'b0;
        fetch("ill17");
        chk("ill17_t3", 5'd4, YIN, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0); step();
        chk("ill17_fault", 5'd0, 10'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        clear = 1'b1;
        step(); clear = 1'b0;
        chk("ill17_clear", 5'd0, 10'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Memory never ready: exactly 15 T1 cycles then FAULT
        ir = mk_ir(0, 3, 1, 2); start = 1'b1;
        step(); start = 1'b0;
        chk("tmo_t0", 5'd21, MAR | INC | ZIN, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0); step();
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk("tmo_t1", 5'd20, MRD, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
            step();
        end
        chk("tmo_fault", 5'd0, 10'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        clear = 1'b1;
        step(); clear = 1'b0; mem_ready = 1'b1;
        chk("tmo_clear", 5'd0, 10'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0);

        // clear in T4 (with start high) wins: IDLE, no done pulse
        ir = mk_ir(3, 1, 2, 3); start = 1'b1;
        step(); start = 1'b0;
        fetch("clr");
        chk("clr_t3", 5'd3, YIN, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0); step();
        clear = 1'b1; start = 1'b1;
        chk("clr_t4", 5'd4, ZIN, 16'h0, 5'd3, 1'b1, 1'b0, 1'b0); step();
        clear = 1'b0; start = 1'b0;
        chk("clr_idle", 5'd0, 10'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0); step();
        chk("clr_no_done", 5'd0, 10'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
